// File: rtl/control_mult_sec.sv
// Sequencing FSM and iteration counter for a shift-and-add multiplier datapath.
// Optional feature macro: CONTROL_MULT_EARLY_EXIT_EN (finish as soon as the multiplier is zero).
module control_mult_sec #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 ack,
  input  logic                 lsb_b,
  input  logic                 b_zero,
  output logic                 load,
  output logic                 add,
  output logic                 shift,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] iter
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t state;
  state_t next_state;

`ifndef CONTROL_MULT_EARLY_EXIT_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (init) next_state = LOAD;
      LOAD:    next_state = CHECK;
      CHECK: begin
`ifdef CONTROL_MULT_EARLY_EXIT_EN
        if (b_zero)     next_state = DONE;
        else if (lsb_b) next_state = ADD;
        else            next_state = SHIFT;
`else
        if (lsb_b) next_state = ADD;
        else       next_state = SHIFT;
`endif
      end
      ADD:     next_state = SHIFT;
      // The exit decision uses the counter value before this SHIFT's decrement.
      SHIFT:   next_state = (iter == CNT_ONE) ? DONE : CHECK;
      DONE:    if (ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
      load  <= 1'b0;
      add   <= 1'b0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      load  <= (next_state == LOAD);
      add   <= (next_state == ADD);
      shift <= (next_state == SHIFT);
      busy  <= (next_state != IDLE) && (next_state != DONE);
      done  <= (next_state == DONE);
      if (state == LOAD)
        iter <= CNT_LOAD;
      else if (state == SHIFT)
        iter <= iter - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_control_mult_sec.sv
// Directed bench for control_mult_sec with a behavioural multiplier datapath driven by the strobes.
module tb_control_mult_sec;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       ack;
  logic       lsb_b;
  logic       b_zero;
  logic       load;
  logic       add;
  logic       shift;
  logic       busy;
  logic       done;
  logic [3:0] iter;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic [15:0] ma   = 16'h0000;
  logic [7:0]  mb   = 8'h00;
  logic [15:0] prod = 16'h0000;

  control_mult_sec #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .init(init), .ack(ack), .lsb_b(lsb_b), .b_zero(b_zero),
    .load(load), .add(add), .shift(shift), .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  // Multiplicand / multiplier / product registers as the real datapath would hold them.
  always @(posedge clk) begin
    if (load) begin
      ma   <= {8'h00, op_a};
      mb   <= op_b;
      prod <= 16'h0000;
    end else if (add) begin
      prod <= prod + ma;
    end else if (shift) begin
      ma <= ma << 1;
      mb <= mb >> 1;
    end
  end

  assign lsb_b  = mb[0];
  assign b_zero = (mb == 8'h00);

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          cycles;
    int          adds;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses init for one edge; on return the LOAD cycle is visible.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    op_a = a;
    op_b = b;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  // Walks from the LOAD cycle until done, checking strobe order, one-hotness, busy and iter.
  task automatic runToDone(input logic [7:0] b, input int init_at,
                           output int cyc, output int nload, output int nadd,
                           output int nshift, output int bad);
    int exp_tr[$];
    int code;
    int exp_iter;
    exp_tr.push_back(1);
    for (int i = 0; i < 8; i++) begin
      exp_tr.push_back(0);
      if (b[i]) exp_tr.push_back(2);
      exp_tr.push_back(3);
    end
    cyc = 1; nload = 0; nadd = 0; nshift = 0; bad = 0; exp_iter = 0;
    while (!done && cyc < 100) begin
      code = load ? 1 : add ? 2 : shift ? 3 : 0;
      nload += int'(load); nadd += int'(add); nshift += int'(shift);
      if (int'(load) + int'(add) + int'(shift) > 1) bad++;
      if (busy !== 1'b1) bad++;
      if (int'(iter) != exp_iter) bad++;
      if (cyc - 1 >= exp_tr.size() || exp_tr[cyc - 1] != code) bad++;
      if (load) exp_iter = 8;
      if (shift) exp_iter = exp_iter - 1;
      if (cyc == init_at) init = 1'b1;
      tick();
      cyc++;
    end
  endtask

  // Holds ack low for five cycles, then acknowledges and checks done falls on the next edge.
  task automatic finishOp(input string tag);
    int held = 0;
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      held += int'(done);
      tick();
    end
    checkOutput({tag, " done hold"}, held, 5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput({tag, " done after ack"}, int'(done), 0);
    checkOutput({tag, " busy after ack"}, int'(busy), 0);
  endtask

  initial begin
    int cyc, nload, nadd, nshift, bad;

    vecs[0] = '{a: 8'h05, b: 8'h00, cycles: 18, adds: 0, prod: 16'h0000};
    vecs[1] = '{a: 8'h03, b: 8'hFF, cycles: 26, adds: 8, prod: 16'h02FD};
    vecs[2] = '{a: 8'h05, b: 8'hAA, cycles: 22, adds: 4, prod: 16'h0352};
    vecs[3] = '{a: 8'hFF, b: 8'h81, cycles: 20, adds: 2, prod: 16'h807F};

    rst = 1'b1; init = 1'b0; ack = 1'b0;
    #12;
    checkOutput("reset outputs", int'({load, add, shift, busy, done, iter}), 0);
    rst = 1'b0;
    tick();
    checkOutput("idle outputs", int'({load, add, shift, busy, done, iter}), 0);

    // Asynchronous reset while ADD is active, then a clean restart.
    applyStimulus(8'h03, 8'hFF);
    tick();
    tick();
    checkOutput("reach ADD", int'(add), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", int'({load, add, shift, busy, done, iter}), 0);
    #1 rst = 1'b0;
    tick();
    checkOutput("idle after reset", int'({load, add, shift, busy, done}), 0);
    applyStimulus(8'h03, 8'hFF);
    checkOutput("load after reset", int'(load), 1);

`ifdef CONTROL_MULT_EARLY_EXIT_EN
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("early exit after reset", int'(done), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // B=0x01: multiplier becomes zero after the first SHIFT, so the second CHECK exits.
    applyStimulus(8'h03, 8'h01);
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("early exit done cycle", cyc, 6);
    checkOutput("early exit iter", int'(iter), 7);
    checkOutput("early exit product", int'(prod), 16'h0003);
    finishOp("early exit");
`else
    runToDone(8'hFF, -1, cyc, nload, nadd, nshift, bad);
    checkOutput("post-reset done cycle", cyc, 26);
    checkOutput("post-reset product", int'(prod), 16'h02FD);
    finishOp("post-reset");

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b);
      runToDone(vecs[v].b, -1, cyc, nload, nadd, nshift, bad);
      checkOutput($sformatf("vec%0d done cycle", v), cyc, vecs[v].cycles);
      checkOutput($sformatf("vec%0d loads", v), nload, 1);
      checkOutput($sformatf("vec%0d adds", v), nadd, vecs[v].adds);
      checkOutput($sformatf("vec%0d shifts", v), nshift, 8);
      checkOutput($sformatf("vec%0d sequence errors", v), bad, 0);
      checkOutput($sformatf("vec%0d iter in done", v), int'(iter), 0);
      checkOutput($sformatf("vec%0d product", v), int'(prod), int'(vecs[v].prod));
      checkOutput($sformatf("vec%0d busy in done", v), int'(busy), 0);
      finishOp($sformatf("vec%0d", v));
    end

    // init raised mid-operation and held through DONE, where ack arrives together with it.
    applyStimulus(8'h02, 8'h03);
    runToDone(8'h03, 4, cyc, nload, nadd, nshift, bad);
    checkOutput("busy-init done cycle", cyc, 20);
    checkOutput("busy-init loads", nload, 1);
    checkOutput("busy-init sequence errors", bad, 0);
    checkOutput("busy-init product", int'(prod), 16'h0006);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("init+ack goes idle", int'({load, add, shift, busy, done}), 0);
    tick();
    init = 1'b0;
    checkOutput("init resampled in idle", int'(load), 1);
    runToDone(8'h03, -1, cyc, nload, nadd, nshift, bad);
    checkOutput("second op done cycle", cyc, 20);
    checkOutput("second op sequence errors", bad, 0);
    finishOp("second op");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
